multicycle_ctrl: RTL

Finite-state controller that sequences the multi-cycle variant of the RV32I datapath. It sits beside the shared ALU, register file and single-ported unified memory. It reads the latched instruction register and a variable-latency memory handshake, then drives per-cycle enables and mux selects so one instruction completes every 3–5+ cycles. It also emits a retire pulse and an illegal-opcode pulse.

---
 rtl/multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: drives datapath enables/selects per state and pulses retire/illegal.
// Latency: branch 3, ALU/store/jal/jalr 4, load 5 cycles, plus one per cycle mem_ready_i is low in FETCH/MEM.
// Backpressure: mem_req_o/mem_we_o/iord_o are held until mem_ready_i. Optional counters via MC_PERF_CNT_EN.

module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic [1:0]  pc_src_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic [1:0]  mem_to_reg_o,
  output logic [2:0]  state_o,
  output logic        retire_o,
  output logic        illegal_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Datapath select encodings
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_ALURES = 2'b10;
  localparam logic [1:0] A_PC          = 2'b00;
  localparam logic [1:0] A_OLD_PC      = 2'b01;
  localparam logic [1:0] A_RS1         = 2'b10;
  localparam logic [1:0] B_RS2         = 2'b00;
  localparam logic [1:0] B_FOUR        = 2'b01;
  localparam logic [1:0] B_IMM         = 2'b10;
  localparam logic [1:0] OP_ADD        = 2'b00;
  localparam logic [1:0] OP_BRCMP      = 2'b01;
  localparam logic [1:0] OP_FUNCT      = 2'b10;
  localparam logic [1:0] WB_MEM        = 2'b00;
  localparam logic [1:0] WB_ALU        = 2'b01;
  localparam logic [1:0] WB_LINK       = 2'b10;

  state_t     state_q;
  state_t     state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r;
  logic       is_i;
  logic       is_ld;
  logic       is_st;
  logic       is_br;
  logic       is_jal;
  logic       is_jalr;
  logic       is_legal;
  logic       branch_taken;

  // Raw control decode before the reset gate
  logic       mem_req_c;
  logic       mem_we_c;
  logic       iord_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       pc_write_cond_c;
  logic [1:0] pc_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] alu_op_c;
  logic       reg_write_c;
  logic [1:0] mem_to_reg_c;
  logic       retire_c;
  logic       illegal_c;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;

  // Branch resolution (beq/bne); the datapath applies it to pc_write_cond, kept here for debug visibility
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero_i;
      3'b001:  branch_taken = !zero_i;
      default: branch_taken = 1'b0;
    endcase
  end

  // Instruction fields the controller never looks at
  logic unused_ok;
  assign unused_ok = ^{instr_i[31:15], instr_i[11:7], branch_taken};

  // Next-state selection; memory states wait on mem_ready_i, everything else advances every cycle
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: state_d = is_legal ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (is_br)
          state_d = S_FETCH;
        else if (is_ld || is_st)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (!mem_ready_i)
          state_d = S_MEM;
        else if (is_ld)
          state_d = S_WB;
        else
          state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  // Per-state control decode
  always_comb begin
    mem_req_c       = 1'b0;
    mem_we_c        = 1'b0;
    iord_c          = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_src_c        = PC_SRC_ALU;
    alu_src_a_c     = A_PC;
    alu_src_b_c     = B_RS2;
    alu_op_c        = OP_ADD;
    reg_write_c     = 1'b0;
    mem_to_reg_c    = WB_MEM;
    retire_c        = 1'b0;
    illegal_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed while the fetch is outstanding and committed in the ready cycle
        mem_req_c   = 1'b1;
        iord_c      = 1'b0;
        alu_src_a_c = A_PC;
        alu_src_b_c = B_FOUR;
        alu_op_c    = OP_ADD;
        if (mem_ready_i) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_src_c   = PC_SRC_ALU;
        end
      end

      S_DECODE: begin
        // Speculatively form old_pc + imm as the branch/jal target
        alu_src_a_c = A_OLD_PC;
        alu_src_b_c = B_IMM;
        alu_op_c    = OP_ADD;
        illegal_c   = !is_legal;
      end

      S_EXEC: begin
        if (is_r) begin
          alu_src_a_c = A_RS1;
          alu_src_b_c = B_RS2;
          alu_op_c    = OP_FUNCT;
        end else if (is_i || is_ld || is_st) begin
          alu_src_a_c = A_RS1;
          alu_src_b_c = B_IMM;
          alu_op_c    = OP_ADD;
        end else if (is_br) begin
          alu_src_a_c     = A_RS1;
          alu_src_b_c     = B_RS2;
          alu_op_c        = OP_BRCMP;
          pc_write_cond_c = 1'b1;
          pc_src_c        = PC_SRC_TARGET;
          retire_c        = 1'b1;
        end else if (is_jal) begin
          pc_write_c = 1'b1;
          pc_src_c   = PC_SRC_TARGET;
        end else if (is_jalr) begin
          alu_src_a_c = A_RS1;
          alu_src_b_c = B_IMM;
          alu_op_c    = OP_ADD;
          pc_write_c  = 1'b1;
          pc_src_c    = PC_SRC_ALURES;
        end
      end

      S_MEM: begin
        // Request/address/we held constant until the memory completes
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = is_st;
        retire_c  = is_st && mem_ready_i;
      end

      S_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        if (is_ld)
          mem_to_reg_c = WB_MEM;
        else if (is_r || is_i)
          mem_to_reg_c = WB_ALU;
        else
          mem_to_reg_c = WB_LINK;
      end

      default: begin
        // Unreachable codes drive nothing and fall back to FETCH
      end
    endcase
  end

  // Reset forces every output to zero combinationally
  assign mem_req_o       = rst_i & mem_req_c;
  assign mem_we_o        = rst_i & mem_we_c;
  assign iord_o          = rst_i & iord_c;
  assign ir_write_o      = rst_i & ir_write_c;
  assign pc_write_o      = rst_i & pc_write_c;
  assign pc_write_cond_o = rst_i & pc_write_cond_c;
  assign pc_src_o        = rst_i ? pc_src_c     : 2'b00;
  assign alu_src_a_o     = rst_i ? alu_src_a_c  : 2'b00;
  assign alu_src_b_o     = rst_i ? alu_src_b_c  : 2'b00;
  assign alu_op_o        = rst_i ? alu_op_c     : 2'b00;
  assign reg_write_o     = rst_i & reg_write_c;
  assign mem_to_reg_o    = rst_i ? mem_to_reg_c : 2'b00;
  assign state_o         = rst_i ? state_q      : 3'd0;
  assign retire_o        = rst_i & retire_c;
  assign illegal_o       = rst_i & illegal_c;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_q;

  // Free-running cycle and retired-instruction counters, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= 32'd0;
      instret_q   <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire_c)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt_o = rst_i ? cycle_cnt_q : 32'd0;
  assign instret_o   = rst_i ? instret_q   : 32'd0;
`else
  assign cycle_cnt_o = 32'd0;
  assign instret_o   = 32'd0;
`endif

endmodule
